// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decodes the immediate at push time and queues
// {imm, imm_err, tag} in a DEPTH-entry FIFO; outputs are driven from the head entry.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst,
    input  logic [6:0]       imm_ctrl,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic             imm_err,
    output logic [TAG_W-1:0] out_tag
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    logic [31:0]      imm32;
    logic             ext_err;
    logic [XLEN-1:0]  ext_imm;

    logic [XLEN-1:0]  mem_imm [DEPTH];
    logic             mem_err [DEPTH];
    logic [TAG_W-1:0] mem_tag [DEPTH];

    logic             unused_opcode;
    assign unused_opcode = ^inst[6:0];

    // Every format is formed as a 32-bit value whose bit 31 is the correct
    // extension bit, so one sign-extension to XLEN serves all of them.
    always_comb begin
        imm32   = '0;
        ext_err = 1'b0;
        case (imm_ctrl)
            7'b000_0001: imm32 = {{20{inst[31]}}, inst[31:20]};
            7'b000_0010: imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            7'b000_0100: imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            7'b000_1000: imm32 = {inst[31:12], 12'b0};
            7'b001_0000: imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            7'b010_0000: imm32 = {27'b0, inst[19:15]};
            7'b100_0000: begin
                if (XLEN == 64) begin
                    imm32 = {26'b0, inst[25:20]};
                end else if (inst[25]) begin
                    ext_err = 1'b1;
                end else begin
                    imm32 = {27'b0, inst[24:20]};
                end
            end
            default: ext_err = 1'b1;
        endcase
    end

    assign ext_imm = XLEN'($signed(imm32));

    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset: outputs are gated by out_valid.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_imm[wr_ptr] <= ext_imm;
            mem_err[wr_ptr] <= ext_err;
            mem_tag[wr_ptr] <= in_tag;
        end
    end

    assign imm     = out_valid ? mem_imm[rd_ptr] : '0;
    assign imm_err = out_valid ? mem_err[rd_ptr] : 1'b0;
    assign out_tag = out_valid ? mem_tag[rd_ptr] : '0;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one input stream
// and are compared against a queue-based reference model.
module tb_imm_gen_pipe;

    localparam int DEPTH = 2;

    typedef struct packed {
        logic [63:0] imm;
        logic        err;
        logic [7:0]  tag;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] inst;
    logic [6:0]  imm_ctrl;
    logic [7:0]  in_tag;
    logic        out_ready;

    logic        in_ready32, out_valid32, imm_err32;
    logic [31:0] imm32;
    logic [7:0]  out_tag32;
    logic        in_ready64, out_valid64, imm_err64;
    logic [63:0] imm64;
    logic [7:0]  out_tag64;

    int vectors = 0;
    int miscompares = 0;

    ent_t q32[$];
    ent_t q64[$];

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .DEPTH(DEPTH), .TAG_W(8)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32),
        .inst(inst), .imm_ctrl(imm_ctrl), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready),
        .imm(imm32), .imm_err(imm_err32), .out_tag(out_tag32)
    );

    imm_gen_pipe #(.XLEN(64), .DEPTH(DEPTH), .TAG_W(8)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64),
        .inst(inst), .imm_ctrl(imm_ctrl), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready),
        .imm(imm64), .imm_err(imm_err64), .out_tag(out_tag64)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", name, obs, exp);
        end
    endtask

    // Reference: field value as a signed integer, scaled, then truncated to XLEN.
    function automatic ent_t model(input logic [31:0] i, input logic [6:0] c,
                                   input logic [7:0] t, input int xl);
        ent_t   e;
        longint v;
        v     = 0;
        e.err = 1'b0;
        e.tag = t;
        if ($countones(c) != 1)  e.err = 1'b1;
        else if (c == 7'h01)     v = longint'($signed(i[31:20]));
        else if (c == 7'h02)     v = longint'($signed({i[31:25], i[11:7]}));
        else if (c == 7'h04)     v = longint'($signed({i[31], i[7], i[30:25], i[11:8]})) * 2;
        else if (c == 7'h08)     v = longint'($signed(i[31:12])) * 4096;
        else if (c == 7'h10)     v = longint'($signed({i[31], i[19:12], i[20], i[30:21]})) * 2;
        else if (c == 7'h20)     v = longint'(i[19:15]);
        else begin
            if (xl == 32 && i[25]) e.err = 1'b1;
            else if (xl == 64)     v = longint'(i[25:20]);
            else                   v = longint'(i[24:20]);
        end
        if (e.err) v = 0;
        e.imm = (xl == 32) ? (v & 64'h0000_0000_FFFF_FFFF) : v;
        return e;
    endfunction

    task automatic check_out();
        ent_t h32, h64;
        logic v;
        v   = (q32.size() != 0);
        h32 = v ? q32[0] : '0;
        h64 = v ? q64[0] : '0;
        chk("out_valid32", out_valid32, v);
        chk("imm32",       imm32,       h32.imm);
        chk("imm_err32",   imm_err32,   h32.err);
        chk("out_tag32",   out_tag32,   h32.tag);
        chk("out_valid64", out_valid64, v);
        chk("imm64",       imm64,       h64.imm);
        chk("imm_err64",   imm_err64,   h64.err);
        chk("out_tag64",   out_tag64,   h64.tag);
    endtask

    // Drive one cycle of inputs (called at a falling edge), update the model
    // at the rising edge, check outputs at the next falling edge.
    task automatic step(input logic v, input logic [31:0] i, input logic [6:0] c,
                        input logic [7:0] t, input logic rdy, input logic fl);
        logic do_push, do_pop;
        in_valid  = v;
        inst      = i;
        imm_ctrl  = c;
        in_tag    = t;
        out_ready = rdy;
        flush     = fl;
        #1;
        chk("in_ready32", in_ready32, q32.size() != DEPTH);
        chk("in_ready64", in_ready64, q64.size() != DEPTH);
        do_push = v && (q32.size() != DEPTH) && !fl;
        do_pop  = (q32.size() != 0) && rdy;
        @(posedge clk);
        if (fl) begin
            q32.delete();
            q64.delete();
        end else begin
            if (do_pop) begin
                void'(q32.pop_front());
                void'(q64.pop_front());
            end
            if (do_push) begin
                q32.push_back(model(i, c, t, 32));
                q64.push_back(model(i, c, t, 64));
            end
        end
        @(negedge clk);
        check_out();
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 32'h0, 7'h01, 8'h00, rdy, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        inst      = '0;
        imm_ctrl  = '0;
        in_tag    = '0;
        out_ready = 1'b0;

        #3;
        chk("rst_out_valid", out_valid32, 1'b0);
        chk("rst_imm64",     imm64,       64'h0);
        chk("rst_out_tag",   out_tag32,   8'h00);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", in_ready32, 1'b1);

        // I format
        step(1'b1, 32'hFFF00093, 7'h01, 8'h05, 1'b1, 1'b0);
        chk("i_imm",   imm32,     64'hFFFF_FFFF);
        chk("i_tag",   out_tag32, 8'h05);
        idle(1'b1);
        chk("i_drain", out_valid32, 1'b0);

        // S then J back-to-back
        step(1'b1, 32'hFE112E23, 7'h02, 8'h11, 1'b1, 1'b0);
        chk("s_imm", imm32, 64'hFFFF_FFFC);
        step(1'b1, 32'hFFDFF06F, 7'h10, 8'h12, 1'b1, 1'b0);
        chk("j_imm", imm32, 64'hFFFF_FFFC);
        chk("j_tag", out_tag32, 8'h12);

        // U, SH, Z, bad select
        step(1'b1, 32'h800000B7, 7'h08, 8'h20, 1'b1, 1'b0);
        chk("u_imm64", imm64, 64'hFFFF_FFFF_8000_0000);
        chk("u_imm32", imm32, 64'h8000_0000);
        step(1'b1, 32'h03F01093, 7'h40, 8'h21, 1'b1, 1'b0);
        chk("sh_imm64",  imm64,     64'h3F);
        chk("sh_err32",  imm_err32, 1'b1);
        chk("sh_imm32",  imm32,     64'h0);
        step(1'b1, 32'h000F8073, 7'h20, 8'h22, 1'b1, 1'b0);
        chk("z_imm", imm32, 64'h1F);
        step(1'b1, 32'hFFF00093, 7'h03, 8'h23, 1'b1, 1'b0);
        chk("bad_err", imm_err64, 1'b1);
        chk("bad_imm", imm64,     64'h0);
        idle(1'b1);

        // Backpressure: third push refused, then push-while-full-and-popping refused
        step(1'b1, 32'h00100093, 7'h01, 8'h31, 1'b0, 1'b0);
        step(1'b1, 32'h00200093, 7'h01, 8'h32, 1'b0, 1'b0);
        #1 chk("full_in_ready", in_ready32, 1'b0);
        step(1'b1, 32'h00300093, 7'h01, 8'h33, 1'b0, 1'b0);
        step(1'b1, 32'h00400093, 7'h01, 8'h34, 1'b1, 1'b0);
        chk("bp_order", out_tag32, 8'h32);
        idle(1'b1);
        chk("bp_empty", out_valid32, 1'b0);
        idle(1'b1);

        // Flush with a simultaneous push
        step(1'b1, 32'h00500093, 7'h01, 8'h41, 1'b0, 1'b0);
        step(1'b1, 32'h00600093, 7'h01, 8'h42, 1'b0, 1'b0);
        step(1'b1, 32'h00700093, 7'h01, 8'h43, 1'b0, 1'b1);
        chk("flush_valid", out_valid32, 1'b0);
        idle(1'b1);

        // Async reset mid-drain
        step(1'b1, 32'h00800093, 7'h01, 8'h51, 1'b0, 1'b0);
        step(1'b1, 32'h00900093, 7'h01, 8'h52, 1'b0, 1'b0);
        step(1'b0, 32'h0, 7'h01, 8'h00, 1'b1, 1'b0);
        chk("pre_rst_valid", out_valid32, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid32, 1'b0);
        chk("arst_imm",   imm32,       64'h0);
        chk("arst_tag",   out_tag64,   8'h00);
        q32.delete();
        q64.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("arst_in_ready", in_ready32, 1'b1);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [6:0] c;
            if ($urandom_range(0, 3) != 0) c = 7'(1 << $urandom_range(0, 6));
            else                           c = 7'($urandom_range(0, 127));
            step(1'($urandom_range(0, 3) != 0), $urandom, c, 8'($urandom),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
